// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA (plus optional rotate-right) moving up to STEP bits per clock.
// Optional feature macro: ITERATIVE_SHIFTER_ROTATE_EN (mode 11 = rotate right; otherwise mode 11 acts as SRL).
module iterative_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [WIDTH-1:0]           a,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] STEP_W  = (SW+1)'(STEP);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] result_reg;
    logic [SW-1:0]    count_reg;
    logic [1:0]       mode_reg;
    logic             sign_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [SW-1:0]    k;
    logic [SW-1:0]    count_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] sign_fill;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    logic [SW:0]      rot_amt;
`endif

    // Per-cycle step: k = min(count, STEP). count never exceeds WIDTH-1, so k fits SW bits.
    always_comb begin
        if ({1'b0, count_reg} < STEP_W)
            k = count_reg;
        else
            k = STEP_W[SW-1:0];
        count_next = count_reg - k;
    end

    always_comb begin
        // SRA fills from the sign latched at accept, not the live MSB of data.
        sign_fill = sign_reg ? ~({WIDTH{1'b1}} >> k) : '0;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        rot_amt   = WIDTH_W - {1'b0, k};
`endif
        case (mode_reg)
            2'b00:   shifted = data_reg << k;
            2'b01:   shifted = data_reg >> k;
            2'b10:   shifted = (data_reg >> k) | sign_fill;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            default: shifted = (data_reg >> k) | (data_reg << rot_amt);
`else
            default: shifted = data_reg >> k;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            mode_reg   <= 2'b00;
            sign_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        data_reg  <= a;
                        count_reg <= shamt;
                        mode_reg  <= mode;
                        sign_reg  <= a[WIDTH-1];
                        if (shamt == '0) begin
                            state_reg  <= DONE;
                            result_reg <= a;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_reg  <= shifted;
                    count_reg <= count_next;
                    if (count_next == '0) begin
                        state_reg  <= DONE;
                        result_reg <= shifted;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end else begin
                        busy_reg <= 1'b1;
                        done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule
